// File: rtl/cim_pkg.sv
// Shared constants, FSM encoding and helpers for the CIM weight loader.
// The optional parity check is enabled with the CIM_WL_PARITY_EN macro.
package cim_pkg;

  localparam int CIM_DATA_W    = 24;
  localparam int CIM_ROWS      = 8;
  localparam int CIM_SETUP_CYC = 1;
  localparam int CIM_PULSE_CYC = 1;
  localparam int CIM_HOLD_CYC  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } cim_state_e;

  function automatic int cim_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cim_wl_timer.sv
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
// expired is high while the count sits at zero, i.e. in the last cycle of a phase.
module cim_wl_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/cim_weight_loader.sv
// Write sequencer for the two-bank CIM weight array: setup/strobe/hold per row.
// Define CIM_WL_PARITY_EN to add the in_parity input and the sticky par_err output.
module cim_weight_loader
  import cim_pkg::*;
#(
  parameter int DATA_W    = CIM_DATA_W,
  parameter int ROWS      = CIM_ROWS,
  parameter int SETUP_CYC = CIM_SETUP_CYC,
  parameter int PULSE_CYC = CIM_PULSE_CYC,
  parameter int HOLD_CYC  = CIM_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    bank_sel,
  input  logic                    both_banks,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
`ifdef CIM_WL_PARITY_EN
  input  logic                    in_parity,
  output logic                    par_err,
`endif
  output logic [DATA_W-1:0]       D,
  output logic [ROWS-1:0]         WA0,
  output logic [ROWS-1:0]         WA1,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    bank_idx
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int TMR_W = $clog2(cim_max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

  cim_state_e       state;
  logic             both_r;
  logic             second_r;
  logic             word_ok;
  logic             accept;
  logic             last_row;
  logic             tmr_load;
  logic             tmr_exp;
  logic [TMR_W-1:0] tmr_val;
  logic [ROWS-1:0]  row_strobe;

`ifdef CIM_WL_PARITY_EN
  assign word_ok = ~(^{in_data, in_parity});
`else
  assign word_ok = 1'b1;
`endif

  assign accept     = in_valid & in_ready;
  assign last_row   = (row_idx == ROW_W'(ROWS - 1));
  assign row_strobe = ROWS'(1) << row_idx;

  // Each phase loads its length minus one so expiry lands on the phase's final cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      WAIT:  if (accept && word_ok) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(SETUP_CYC - 1);
             end
      SETUP: if (tmr_exp) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(PULSE_CYC - 1);
             end
      PULSE: if (tmr_exp) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(HOLD_CYC - 1);
             end
      default: ;
    endcase
  end

  cim_wl_timer #(
    .CNT_W    (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      D        <= '0;
      WA0      <= '0;
      WA1      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      row_idx  <= '0;
      bank_idx <= 1'b0;
      both_r   <= 1'b0;
      second_r <= 1'b0;
`ifdef CIM_WL_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
                bank_idx <= bank_sel;
                both_r   <= both_banks;
                second_r <= 1'b0;
                row_idx  <= '0;
                busy     <= 1'b1;
                in_ready <= 1'b1;
                state    <= WAIT;
`ifdef CIM_WL_PARITY_EN
                par_err  <= 1'b0;
`endif
              end
        // A rejected word is swallowed here; ready stays high for its replacement.
        WAIT: if (accept) begin
                if (word_ok) begin
                  D        <= in_data;
                  in_ready <= 1'b0;
                  state    <= SETUP;
                end
`ifdef CIM_WL_PARITY_EN
                if (!word_ok) par_err <= 1'b1;
`endif
              end
        SETUP: if (tmr_exp) begin
                 if (bank_idx) WA1 <= row_strobe;
                 else          WA0 <= row_strobe;
                 state <= PULSE;
               end
        PULSE: if (tmr_exp) begin
                 WA0   <= '0;
                 WA1   <= '0;
                 state <= HOLD;
               end
        HOLD: if (tmr_exp) begin
                if (last_row && (second_r || !both_r)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
                end else begin
                  if (last_row) begin
                    row_idx  <= '0;
                    bank_idx <= ~bank_idx;
                    second_r <= 1'b1;
                  end else begin
                    row_idx  <= row_idx + 1'b1;
                  end
                  in_ready <= 1'b1;
                  state    <= WAIT;
                end
              end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_weight_loader.sv
// Directed bench for cim_weight_loader with a strobe scoreboard; a second
// instance with stretched setup/pulse/hold timing checks the phase windows.
module tb_cim_weight_loader;
  import cim_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, bank_sel, both_banks, in_valid, in_ready;
  logic [23:0] in_data, D;
  logic [7:0]  WA0, WA1;
  logic        busy, done, bank_idx;
  logic [2:0]  row_idx;
`ifdef CIM_WL_PARITY_EN
  logic        in_parity, par_err;
  logic        in_parity_t, par_err_t;
`endif

  logic        rst_t, start_t, valid_t, ready_t, busy_t, done_t, bank_t;
  logic [23:0] data_t, D_t;
  logic [7:0]  WA0_t, WA1_t;
  logic [2:0]  row_t;

  cim_weight_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel), .both_banks(both_banks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef CIM_WL_PARITY_EN
    .in_parity(in_parity), .par_err(par_err),
`endif
    .D(D), .WA0(WA0), .WA1(WA1), .busy(busy), .done(done),
    .row_idx(row_idx), .bank_idx(bank_idx)
  );

  cim_weight_loader #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_tim (
    .clk(clk), .rst(rst_t), .start(start_t), .bank_sel(1'b0), .both_banks(1'b0),
    .in_valid(valid_t), .in_ready(ready_t), .in_data(data_t),
`ifdef CIM_WL_PARITY_EN
    .in_parity(in_parity_t), .par_err(par_err_t),
`endif
    .D(D_t), .WA0(WA0_t), .WA1(WA1_t), .busy(busy_t), .done(done_t),
    .row_idx(row_t), .bank_idx(bank_t)
  );

  typedef struct {
    logic        bank;
    logic [2:0]  row;
    logic [23:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic        m_bank, m_both, m_second, m_active;
  logic [2:0]  m_row;
  logic        in_strb, accepted;
  int          strb_len, strobes, done_cnt, done_cyc, start_cyc;
  logic [23:0] strb_d, prev_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        acc, rst_e, ok, wa_any;
    logic [7:0]  oh;
    logic [15:0] exp16;
    exp_t        e;
    acc   = in_valid && in_ready;
    rst_e = rst;
    ok    = 1'b1;
`ifdef CIM_WL_PARITY_EN
    ok = ~(^{in_data, in_parity});
`endif
    @(posedge clk);
    #1;
    cyc++;
    accepted = acc && !rst_e;
    if (rst_e) begin
      in_strb  = 1'b0;
      m_active = 1'b0;
      prev_d   = D;
      return;
    end
    if (acc && ok && m_active) begin
      e.bank = m_bank; e.row = m_row; e.data = in_data; e.cyc = cyc;
      sb.push_back(e);
      if (m_row == 3'd7) begin
        if (m_both && !m_second) begin
          m_row = 3'd0; m_bank = ~m_bank; m_second = 1'b1;
        end
      end else begin
        m_row = m_row + 3'd1;
      end
    end
    wa_any = |{WA1, WA0};
    check("onehot", 32'(($countones(WA0) + $countones(WA1)) <= 1), 1);
    if (in_ready) check("ready_without_strobe", 32'(wa_any), 0);
    if (wa_any) check("d_stable_while_strobe", D, prev_d);
    if (wa_any && !in_strb) begin
      strobes++;
      check("strobe_has_word", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e     = sb.pop_front();
        oh    = 8'h01 << e.row;
        exp16 = e.bank ? {oh, 8'h00} : {8'h00, oh};
        check("wa_pattern", {WA1, WA0}, exp16);
        check("d_at_strobe", D, e.data);
        check("d_before_strobe", prev_d, e.data);
        check("strobe_latency", 32'(cyc - e.cyc), 1);
        check("row_idx", row_idx, e.row);
        check("bank_idx", bank_idx, e.bank);
      end
      in_strb = 1'b1; strb_len = 1; strb_d = D;
    end else if (wa_any) begin
      strb_len++;
    end else if (in_strb) begin
      check("pulse_len", strb_len, 1);
      check("d_after_strobe", D, strb_d);
      in_strb = 1'b0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_low_at_done", busy, 0);
    end
    prev_d = D;
  endtask

  task automatic do_start(input logic bs, input logic bb);
    start = 1'b1; bank_sel = bs; both_banks = bb;
    m_bank = bs; m_both = bb; m_second = 1'b0; m_row = 3'd0; m_active = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", busy, 1);
    check("ready_after_start", in_ready, 1);
  endtask

  task automatic run_load(input int mode, input int base, input int bad_at, input int budget);
    int widx, d0;
    widx = 0;
    d0   = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      in_valid = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      in_data  = 24'(base + widx);
      if (widx == bad_at) in_data = 24'hBAD000 | 24'(widx);
`ifdef CIM_WL_PARITY_EN
      in_parity = (^in_data) ^ (widx == bad_at);
`endif
      tick();
      if (accepted) widx++;
    end
    in_valid = 1'b0;
    check("done_within_budget", 32'(done_cnt - d0), 1);
  endtask

  task automatic post_load(input int d0);
    for (int i = 0; i < 3; i++) tick();
    check("done_once", 32'(done_cnt - d0), 1);
    check("scoreboard_drained", 32'(sb.size()), 0);
    check("busy_idle", busy, 0);
    check("ready_idle", in_ready, 0);
  endtask

  logic [7:0]  wa_h [32];
  logic [23:0] d_h  [32];

  initial begin
    int d0, s0, i0, i1, len, t_acc;
    logic found, acc_t;
    rst = 1'b1; rst_t = 1'b1; start = 1'b0; bank_sel = 1'b0; both_banks = 1'b0;
    in_valid = 1'b0; in_data = '0; start_t = 1'b0; valid_t = 1'b0; data_t = '0;
    m_active = 1'b0; in_strb = 1'b0; strb_len = 0; strobes = 0; done_cnt = 0;
    done_cyc = 0; start_cyc = 0; prev_d = '0; strb_d = '0; accepted = 1'b0;
`ifdef CIM_WL_PARITY_EN
    in_parity = 1'b0; in_parity_t = 1'b0;
`endif
    tick(); tick();
    check("rst_D", D, 0);
    check("rst_WA0", WA0, 0);
    check("rst_WA1", WA1, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_bank_idx", bank_idx, 0);
    rst = 1'b0; rst_t = 1'b0;
    tick();

    // single bank, words 1..8, valid always high
    d0 = done_cnt; s0 = strobes;
    do_start(1'b0, 1'b0);
    run_load(0, 1, -1, 60);
    check("done_cycle_33", 32'(done_cyc - start_cyc), 32);
    post_load(d0);
    check("single_bank_strobes", 32'(strobes - s0), 8);
    check("d_retained_idle", D, 24'h000008);

    // both banks, bank1 first
    d0 = done_cnt; s0 = strobes;
    do_start(1'b1, 1'b1);
    run_load(0, 'h100, -1, 100);
    post_load(d0);
    check("both_bank_strobes", 32'(strobes - s0), 16);

    // backpressure pattern 1,0,0,1
    d0 = done_cnt; s0 = strobes;
    do_start(1'b0, 1'b0);
    run_load(1, 'h200, -1, 200);
    post_load(d0);
    check("bp_strobes", 32'(strobes - s0), 8);

    // reset while row 3 strobes
    do_start(1'b0, 1'b0);
    found = 1'b0; t_acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (WA0 == 8'h08) begin found = 1'b1; break; end
      in_valid = 1'b1;
      in_data  = 24'h000300 + 24'(t_acc);
`ifdef CIM_WL_PARITY_EN
      in_parity = ^in_data;
`endif
      tick();
      if (accepted) t_acc++;
    end
    check("row3_strobe_seen", 32'(found), 1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("midrst_WA0", WA0, 0);
    check("midrst_WA1", WA1, 0);
    check("midrst_busy", busy, 0);
    check("midrst_D", D, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    sb.delete();
    tick();
    d0 = done_cnt;
    do_start(1'b0, 1'b0);
    run_load(0, 'h400, -1, 60);
    post_load(d0);

`ifdef CIM_WL_PARITY_EN
    // bad parity on the third word: row 2 must come from the next good word
    d0 = done_cnt; s0 = strobes;
    do_start(1'b0, 1'b0);
    run_load(0, 'h500, 2, 80);
    check("par_err_set", par_err, 1);
    post_load(d0);
    check("par_err_sticky", par_err, 1);
    check("parity_strobes", 32'(strobes - s0), 8);
    d0 = done_cnt;
    do_start(1'b0, 1'b0);
    check("par_err_cleared_on_start", par_err, 0);
    run_load(0, 'h600, -1, 60);
    post_load(d0);
`endif

    // stretched timing instance: setup 2, pulse 3, hold 2
    start_t = 1'b1;
    tick();
    start_t = 1'b0; valid_t = 1'b1; data_t = 24'hA00000; t_acc = 0;
`ifdef CIM_WL_PARITY_EN
    in_parity_t = ^data_t;
`endif
    for (int i = 0; i < 32; i++) begin
      acc_t = valid_t && ready_t;
      tick();
      wa_h[i] = WA0_t;
      d_h[i]  = D_t;
      check("t_wa1_zero", WA1_t, 0);
      if (acc_t) begin
        t_acc++;
        data_t = 24'hA00000 + 24'(t_acc);
`ifdef CIM_WL_PARITY_EN
        in_parity_t = ^data_t;
`endif
      end
    end
    i0 = -1; i1 = -1; len = 0;
    for (int i = 0; i < 32; i++) if (i0 < 0 && wa_h[i] != 0) i0 = i;
    check("t_strobe_found", 32'(i0 >= 2 && i0 < 16), 1);
    if (i0 >= 2 && i0 < 16) begin
      for (int j = i0; j < 32; j++) begin
        if (wa_h[j] == 0) break;
        len++;
      end
      check("t_pulse_len", len, 3);
      check("t_first_row", wa_h[i0], 8'h01);
      for (int k = i0 - 2; k < i0 + len + 2; k++) check("t_d_window", d_h[k], 24'hA00000);
      for (int j = i0 + len; j < 32; j++) if (i1 < 0 && wa_h[j] != 0) i1 = j;
      check("t_row_period", 32'(i1 - i0), 8);
      if (i1 > 0) check("t_second_row", wa_h[i1], 8'h02);
    end
    rst_t = 1'b1; valid_t = 1'b0;
    tick();
    rst_t = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
